// File: rtl/byte_load_pkg.sv
// byte_load_pkg: shared CPU datapath constants and the byte_load FSM state encoding.
package byte_load_pkg;
    localparam int DATA_W = 16;
    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;
    typedef enum logic [1:0] {IDLE = 2'd0, RD1 = 2'd1, RD2 = 2'd2, FIN = 2'd3} state_t;
endpackage

// File: rtl/byte_load_extend.sv
// byte_extend: little-endian byte lane select with zero/sign extension to a full register word.
module byte_extend
    import byte_load_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic              lane,
    input  logic              sext,
    output logic [DATA_W-1:0] result
);
    logic [7:0] b;
    always_comb begin
        b = lane ? word[15:8] : word[7:0];
        result = {{8{sext & b[7]}}, b};
    end
endmodule

// File: rtl/byte_load.sv
// byte_load: fetches data-memory words and returns a whole word or an extended byte lane.
// UNALIGNED_WORD_EN enables two-read odd-address word loads; otherwise they are rejected with err.
module byte_load
    import byte_load_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic              size,
    input  logic              sext,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] data_out,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic              lane_q, lane_d, size_q, size_d, sext_q, sext_d;
    logic              mem_req_q, mem_req_d, done_q, done_d, err_q, err_d, rej_q, rej_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] result_q, result_d, data_out_q, data_out_d, ext;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              reject_in, split_rd;

`ifdef UNALIGNED_WORD_EN
    assign reject_in = 1'b0;
    assign split_rd  = size_q == SIZE_WORD && lane_q;
`else
    assign reject_in = size == SIZE_WORD && addr[0];
    assign split_rd  = 1'b0;
`endif

    byte_extend u_ext (.word(mem_rdata), .lane(lane_q), .sext(sext_q), .result(ext));

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        size_d     = size_q;
        sext_d     = sext_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        result_d   = result_q;
        data_out_d = data_out_q;
        cnt_d      = cnt_q;
        rej_d      = rej_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                lane_d = addr[0];
                size_d = size;
                sext_d = sext;
                cnt_d  = '0;
                rej_d  = reject_in;
                if (reject_in) begin
                    result_d = '0;
                    state_d  = FIN;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = addr & ~ADDR_W'(1);
                    state_d    = RD1;
                end
            end
`ifdef UNALIGNED_WORD_EN
            RD1, RD2: begin
`else
            RD1: begin
`endif
                if (mem_ack) begin
                    cnt_d = '0;
                    if (state_q == RD1 && split_rd) begin
                        // upper byte of the first word is the low byte of the result
                        result_d   = {8'h00, mem_rdata[15:8]};
                        mem_addr_d = mem_addr_q + ADDR_W'(2);
                        state_d    = RD2;
                    end else begin
                        result_d  = state_q == RD2 ? {mem_rdata[7:0], result_q[7:0]} :
                                    size_q == SIZE_BYTE ? ext : mem_rdata;
                        mem_req_d = 1'b0;
                        state_d   = FIN;
                    end
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    mem_req_d  = 1'b0;
                    data_out_d = '0;
                    err_d      = 1'b1;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIN: begin
                data_out_d = result_q;
                err_d      = rej_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lane_q     <= 1'b0;
            size_q     <= 1'b0;
            sext_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            result_q   <= '0;
            data_out_q <= '0;
            cnt_q      <= '0;
            rej_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            size_q     <= size_d;
            sext_q     <= sext_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            result_q   <= result_d;
            data_out_q <= data_out_d;
            cnt_q      <= cnt_d;
            rej_q      <= rej_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign busy     = state_q != IDLE;
    assign done     = done_q;
    assign err      = err_q;
    assign data_out = data_out_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
endmodule

// File: tb/tb_byte_load.sv
// tb_byte_load: directed checks of byte_load with TIMEOUT=8; adapts to UNALIGNED_WORD_EN.
module tb_byte_load;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, size = 1'b0, sext = 1'b0, mem_ack = 1'b0;
    logic [15:0] addr = '0, mem_rdata = '0, data_out, mem_addr;
    logic        busy, done, err, mem_req;
    int          checks = 0, fails = 0;

    byte_load #(.ADDR_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .size(size), .sext(sext),
        .busy(busy), .done(done), .err(err), .data_out(data_out),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [15:0] a, input logic sz, input logic sx);
        addr = a; size = sz; sext = sx; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic ack(input logic [15:0] d);
        mem_rdata = d; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst data", data_out, 16'h0000);
        chk("rst req", mem_req, 0);
        chk("rst maddr", mem_addr, 16'h0000);
        step();
        rst = 1'b0;
        step();

        go(16'h1001, 1'b1, 1'b0);
        chk("t1 req", mem_req, 1);
        chk("t1 maddr", mem_addr, 16'h1000);
        chk("t1 busy", busy, 1);
        ack(16'h80AB);
        chk("t1 req drop", mem_req, 0);
        chk("t1 no done yet", done, 0);
        step();
        chk("t1 done", done, 1);
        chk("t1 err", err, 0);
        chk("t1 data", data_out, 16'h0080);
        chk("t1 idle", busy, 0);
        step();
        chk("t1 done pulse", done, 0);

        go(16'h2000, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin addr = 16'h3333; start = 1'b1; end
            step();
            start = 1'b0;
            chk("t2 req held", mem_req, 1);
            chk("t2 maddr held", mem_addr, 16'h2000);
            chk("t2 no done", done, 0);
        end
        ack(16'h00F3);
        step();
        chk("t2 done", done, 1);
        chk("t2 data", data_out, 16'hFFF3);
        chk("t2 err", err, 0);
        step();
        chk("t2 no extra req", mem_req, 0);
        chk("t2 no extra done", done, 0);
        chk("t2 idle", busy, 0);

        go(16'hFFFF, 1'b0, 1'b0);
`ifdef UNALIGNED_WORD_EN
        chk("t3 req1", mem_req, 1);
        chk("t3 maddr1", mem_addr, 16'hFFFE);
        ack(16'h34AA);
        chk("t3 req2", mem_req, 1);
        chk("t3 maddr2 wrap", mem_addr, 16'h0000);
        chk("t3 no done mid", done, 0);
        ack(16'hBB12);
        chk("t3 req drop", mem_req, 0);
        step();
        chk("t3 done", done, 1);
        chk("t3 data", data_out, 16'h1234);
        chk("t3 err", err, 0);
`else
        chk("t3 no req", mem_req, 0);
        chk("t3 busy", busy, 1);
        step();
        chk("t3 done", done, 1);
        chk("t3 err", err, 1);
        chk("t3 data", data_out, 16'h0000);
        chk("t3 still no req", mem_req, 0);
`endif
        step();

        go(16'h0006, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step();
        chk("t4a req before tmo", mem_req, 1);
        ack(16'hC3C3);
        chk("t4a req drop", mem_req, 0);
        chk("t4a no early done", done, 0);
        step();
        chk("t4a done", done, 1);
        chk("t4a err", err, 0);
        chk("t4a data", data_out, 16'hC3C3);
        step();

        go(16'h0008, 1'b1, 1'b0);
        chk("t5 req", mem_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5 async req", mem_req, 0);
        chk("t5 async busy", busy, 0);
        chk("t5 async data", data_out, 16'h0000);
        chk("t5 async done", done, 0);
        mem_rdata = 16'h1111; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        chk("t5 no done in rst", done, 0);
        rst = 1'b0;
        step();
        chk("t5 no done after rst", done, 0);
        go(16'h0002, 1'b0, 1'b1);
        chk("t5 maddr", mem_addr, 16'h0002);
        ack(16'h5A5A);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5 done", done, 1);
        chk("t5 data", data_out, 16'h5A5A);
        chk("t5 fin start ignored", mem_req, 0);
        step();
        chk("t5 still idle", busy, 0);

        go(16'h0004, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t4b req waiting", mem_req, 1);
            chk("t4b no done waiting", done, 0);
        end
        step();
        chk("t4b done", done, 1);
        chk("t4b err", err, 1);
        chk("t4b data", data_out, 16'h0000);
        chk("t4b req low", mem_req, 0);
        chk("t4b idle", busy, 0);
        step();
        chk("t4b done pulse", done, 0);
        chk("t4b req stays low", mem_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
